led_share_scheduler: RTL



---
 rtl/led_share_pkg.sv | 34 +++
 rtl/led_share_scheduler_prescaler.sv | 29 ++
 rtl/led_share_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/led_share_pkg.sv
// Shared types and helpers for the LED bank time-share scheduler.
package led_share_pkg;

  typedef enum logic [1:0] {ARB, SHOW, GAP} state_t;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  // Bits needed for a counter running 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set request strictly after ptr, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr,
                                                input int unsigned        n);
    logic [IDX_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k <= n) && req[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/led_share_scheduler_prescaler.sv
// Scheduler tick prescaler: free-runs 0..TICK_DIV-1 while clr is low.
module led_tick_prescaler
  import led_share_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = cnt_w(TICK_DIV);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == CNT_W'(TICK_DIV - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_c = !clr && (cnt == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/led_share_scheduler.sv
// Round-robin time-share of the LEDG bank among NUM_REQ requesters.
// Define LED_SHARE_PREEMPT_EN to give requester 0 preemptive priority.
module led_share_scheduler
  import led_share_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LED_W       = 8,
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned DWELL_TICKS = 500,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pattern,
  input  logic [NUM_REQ-1:0]       blink_en,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     ack,
  output logic                     done,
  output logic [LED_W-1:0]         LEDG
);

  localparam int unsigned PTR_W   = cnt_w(NUM_REQ);
  localparam int unsigned DWELL_W = cnt_w(DWELL_TICKS);
  localparam int unsigned BLINK_W = cnt_w(BLINK_TICKS);
  localparam int unsigned GAP_W   = cnt_w(GAP_CYCLES);
`ifdef LED_SHARE_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               ack_d, done_d;
  logic [LED_W-1:0]   ledg_d, pat_q, pat_d;
  logic [PTR_W-1:0]   owner_q, owner_d, rr_q, rr_d, pick_c;
  logic               blink_q, blink_d, phase_q, phase_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tick_c, expire_c, abort_c, prio_c;

  led_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (system1000),
    .rst_n  (system1000_rstn),
    .clr    (state_q != SHOW),
    .tick_c (tick_c)
  );

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q <= ARB;
      grant   <= '0;
      ack     <= 1'b0;
      done    <= 1'b0;
      LEDG    <= '0;
      owner_q <= '0;
      pat_q   <= '0;
      blink_q <= 1'b0;
      phase_q <= 1'b1;
      dwell_q <= '0;
      bcnt_q  <= '0;
      gap_q   <= '0;
      rr_q    <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      ack     <= ack_d;
      done    <= done_d;
      LEDG    <= ledg_d;
      owner_q <= owner_d;
      pat_q   <= pat_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    ledg_d   = LEDG;
    owner_d  = owner_q;
    pat_d    = pat_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    dwell_d  = dwell_q;
    bcnt_d   = bcnt_q;
    gap_d    = gap_q;
    rr_d     = rr_q;
    prio_c   = PREEMPT && req[0];
    pick_c   = prio_c ? '0 : PTR_W'(rr_pick(MAX_REQ'(req), IDX_W'(rr_q), NUM_REQ));
    expire_c = tick_c && (dwell_q == DWELL_W'(DWELL_TICKS - 1));
    abort_c  = !req[owner_q] || (prio_c && (owner_q != '0));

    case (state_q)
      ARB: begin
        grant_d = '0;
        ledg_d  = '0;
        if (|req) begin
          state_d = SHOW;
          grant_d = NUM_REQ'(1) << pick_c;
          ack_d   = 1'b1;
          owner_d = pick_c;
          pat_d   = pattern[32'(pick_c) * LED_W +: LED_W];
          blink_d = blink_en[pick_c];
          ledg_d  = pat_d;
          phase_d = 1'b1;
          dwell_d = '0;
          bcnt_d  = '0;
          if (!prio_c) rr_d = pick_c;
        end
      end

      SHOW: begin
        if (tick_c) begin
          dwell_d = dwell_q + 1'b1;
          if (blink_q) begin
            if (bcnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
              bcnt_d  = '0;
              phase_d = !phase_q;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        // Expiry outranks a request drop or preemption in the same cycle.
        if (expire_c || abort_c) begin
          state_d = GAP;
          done_d  = expire_c;
          grant_d = '0;
          ledg_d  = '0;
          gap_d   = '0;
        end else begin
          ledg_d = phase_d ? pat_q : '0;
        end
      end

      GAP: begin
        grant_d = '0;
        ledg_d  = '0;
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ARB;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = ARB;
    endcase
  end

endmodule
